// File: rtl/mnist_argmax_classifier_if.sv
// Score stream in and argmax result out for the MNIST classifier stage.
// The stage itself uses the slave view; whoever feeds scores uses the master view.
interface mnist_argmax_classifier_if #(
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
);
  logic                        start;
  logic                        score_valid;
  logic signed [ACC_WIDTH-1:0] score_data;
  logic                        score_last;
  logic                        busy;
  logic                        ready;
  logic [NUM_CLASSES-1:0]      classes;
  logic [IDX_WIDTH-1:0]        class_idx;
  logic signed [ACC_WIDTH-1:0] max_score;
  logic                        error;

  modport master (
    output start, score_valid, score_data, score_last,
    input  busy, ready, classes, class_idx, max_score, error
  );

  modport slave (
    input  start, score_valid, score_data, score_last,
    output busy, ready, classes, class_idx, max_score, error
  );
endinterface

// File: rtl/mnist_argmax_classifier.sv
// Running-maximum argmax over the NUM_CLASSES scores of one image.
// The result is presented as one-hot and binary index, flagged by ready.
module mnist_argmax_classifier #(
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input logic clk,
  input logic reset,
  mnist_argmax_classifier_if.slave link
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [ACC_WIDTH-1:0] MOST_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [NUM_CLASSES-1:0] ONE_HOT0 = {{(NUM_CLASSES-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [IDX_WIDTH-1:0]        count_q, count_d;
  logic signed [ACC_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]        run_idx_q, run_idx_d;
  logic                        ready_q, ready_d;
  logic                        error_q, error_d;
  logic [NUM_CLASSES-1:0]      classes_q, classes_d;
  logic [IDX_WIDTH-1:0]        class_idx_q, class_idx_d;
  logic signed [ACC_WIDTH-1:0] max_score_q, max_score_d;

  logic                        take;
  logic signed [ACC_WIDTH-1:0] cand_max;
  logic [IDX_WIDTH-1:0]        cand_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      classes_q   <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      classes_q   <= classes_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    ready_d     = ready_q;
    error_d     = error_q;
    classes_d   = classes_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;

    // Strict compare so an equal later score never displaces an earlier winner.
    take     = link.score_data > run_max_q;
    cand_max = take ? link.score_data : run_max_q;
    cand_idx = take ? count_q : run_idx_q;

    if (link.start) begin
      state_d     = COLLECT;
      count_d     = '0;
      run_max_d   = MOST_NEG;
      run_idx_d   = '0;
      ready_d     = 1'b0;
      error_d     = 1'b0;
      classes_d   = '0;
      class_idx_d = '0;
      max_score_d = '0;
    end else if (state_q == COLLECT && link.score_valid) begin
      count_d   = count_q + 1'b1;
      run_max_d = cand_max;
      run_idx_d = cand_idx;
      if (count_q == LAST_IDX) begin
        state_d     = DONE;
        ready_d     = 1'b1;
        classes_d   = ONE_HOT0 << cand_idx;
        class_idx_d = cand_idx;
        max_score_d = cand_max;
      end else if (link.score_last) begin
        // Short frame: no winner is reported, the all-ones index marks it.
        state_d     = DONE;
        ready_d     = 1'b1;
        error_d     = 1'b1;
        classes_d   = '0;
        class_idx_d = '1;
        max_score_d = '0;
      end
    end
  end

  assign link.busy      = (state_q == COLLECT);
  assign link.ready     = ready_q;
  assign link.error     = error_q;
  assign link.classes   = classes_q;
  assign link.class_idx = class_idx_q;
  assign link.max_score = max_score_q;

endmodule

// File: doc/mnist_argmax_classifier.md
# mnist_argmax_classifier

- Producer end of the `classes`/`ready` result interface of the MNIST systolic-array inference path.
- Accepts the NUM_CLASSES signed accumulator scores that the last systolic-array column streams out for one image.
- Tracks the running maximum and, after the final score, presents the winning class as a one-hot vector and a binary index, then raises `ready`.
- Sits between the systolic array output and the wrapper's `classes`/`hex_connect` outputs.

## Interface
- `ACC_WIDTH`, 32: width of signed score input (two's complement).
- `NUM_CLASSES`, 10: scores per image; legal range 2..15.
- `IDX_WIDTH`, 4: width of `class_idx`; must satisfy 2**IDX_WIDTH > NUM_CLASSES.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new image, discards any collection in progress.
- `score_valid`  in  1  `score_data` valid this cycle.
- `score_data`  in  ACC_WIDTH  signed score for the current class (class 0 first).
- `score_last`  in  1  qualifies the final score; sampled only with `score_valid`.
- `busy`  out  1  high in COLLECT.
- `ready`  out  1  result valid; held until next `start` or `reset`.
- `classes`  out  NUM_CLASSES  one-hot winner; bit k = class k.
- `class_idx`  out  IDX_WIDTH  binary winner index.
- `max_score`  out  ACC_WIDTH  winning score.
- `error`  out  1  framing error on the last image.

## Operation
- States: IDLE, COLLECT, DONE.
- Reset: IDLE; all outputs 0; internal count 0, running max 0.
- IDLE, `start`=1:
  - Go to COLLECT, count<=0, run_max<=most negative ACC_WIDTH value, run_idx<=0.
  - Clear `ready` and `error`; `classes`, `class_idx`, `max_score` clear to 0.
- IDLE, `score_valid`=1 without `start`: ignored, no state change.
- COLLECT, each `score_valid`=1 cycle:
  - If signed `score_data` > run_max (strict), update run_max<=score_data, run_idx<=count.
  - Ties keep the lower index.
  - count<=count+1.
- COLLECT, the score accepted at count==NUM_CLASSES-1 completes the image (with or without `score_last`):
  - Next cycle DONE; `classes`<=1<<final_idx, `class_idx`<=final_idx, `max_score`<=final_max, `ready`<=1.
  - The compare uses the current score, so a winning final score is included.
- COLLECT, `score_last`=1 with count<NUM_CLASSES-1 is a framing error:
  - Next cycle DONE with `error`=1, `ready`=1, `classes`=0, `class_idx`=all ones, `max_score`=0.
- DONE: outputs held; extra `score_valid` ignored. `start` returns to COLLECT exactly as from IDLE.
- `start` in COLLECT or DONE: restarts identically to IDLE+start; partial data discarded, no error.
- `start` with `score_valid` in the same cycle: restart takes effect, the score is ignored.
- Gaps in `score_valid` are allowed; there is no timeout.
- `reset` at any time: immediate return to IDLE, all outputs 0.

## Timing
- `busy` rises the cycle after `start` and falls the cycle `ready` rises.
- Latency: `ready` rises 1 cycle after the clock edge accepting the final score. Minimum start-to-ready is NUM_CLASSES+1 cycles (11 at default).
- `classes`, `class_idx`, `max_score`, `error` change only on the edge that sets `ready`, or on start/reset clears; all are registered.
- `classes` is exactly one-hot whenever `ready`=1 and `error`=0, and all-zero otherwise.
- Back-to-back images: `start` may be asserted the cycle after `ready` rises.

## Test plan
- Reset check: `reset` asserted mid-COLLECT after 5 scores -> outputs 0 asynchronously. A new `start` plus 10 scores then gives a correct result.
- Basic argmax: `start`, then scores 3,-7,12,40,5,0,-1,39,8,2 on consecutive cycles, `score_last` on the 10th -> `ready` 11 cycles after `start`, `classes`=10'b0000001000, `class_idx`=3, `max_score`=40, `error`=0.
- Negatives, ties and last-wins:
  - All scores -100 except score 6 = -5 and score 9 = -5 -> `class_idx`=6, `classes`=10'b0001000000.
  - Repeat with score 9 = 1000 -> `class_idx`=9, `classes`=10'b1000000000.
  - All ten scores equal to the most negative value -> `class_idx`=0.
- Gapped input: the same data as basic argmax with `score_valid` toggling every other cycle -> identical result. `ready` rises 1 cycle after the 10th valid score. `busy` stays high throughout.
- Framing error: `score_last` on the 4th score -> next cycle `ready`=1, `error`=1, `classes`=0, `class_idx`=4'hF. A following `start` clears `error`, and a 10-score frame then succeeds.
- Restart: `start` re-pulsed after 6 scores, then a full 10-score frame with a maximum at index 2 -> `class_idx`=2, no error. The `score_valid` coinciding with the restart `start` is ignored.
